half_adder_unit: RTL and testbench
==================================

Name: half_adder_unit

Overview:
- Registered, width-parameterised half-adder array: per bit, sum = a XOR b and carry = a AND b.
- Results are captured into an output register with a valid/ready handshake.
- A saturating counter records how many result bits produced a carry.
- Sits as a leaf datapath block. The default WIDTH=1 configuration is the classic 1-bit half adder with one cycle of latency.

Parameters:
- WIDTH, 1, number of independent bit lanes (1..64).
- CNT_W, 16, width of the carry-event counter.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- a  input  WIDTH  operand A, one bit per lane.
- b  input  WIDTH  operand B, one bit per lane.
- in_valid  input  1  a/b hold a new operand pair.
- in_ready  output  1  block accepts the pair this cycle.
- sum  output  WIDTH  registered a XOR b.
- carry  output  WIDTH  registered a AND b.
- out_valid  output  1  sum/carry hold an unconsumed result.
- out_ready  input  1  downstream consumes the result this cycle.
- carry_cnt  output  CNT_W  saturating count of carry bits set in accepted results.
- cnt_clr  input  1  synchronous clear of carry_cnt.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low (clk, rst_n).
- Reset (rst_n=0, takes effect immediately, independent of clk): sum=0, carry=0, out_valid=0, carry_cnt=0.
- in_ready = !out_valid || out_ready. It is combinational; there is no path from in_valid to in_ready.
- Accept: when in_valid && in_ready at a rising edge:
  - sum <= a ^ b and carry <= a & b, bitwise per lane; lanes are fully independent, with no inter-lane carry.
  - out_valid <= 1.
  - Latency is exactly 1 cycle from the accept edge.
- Consume without new accept: when out_valid && out_ready && !(in_valid && in_ready), out_valid <= 0. sum/carry keep their last values.
- Simultaneous consume and accept: the new result replaces the old one and out_valid stays 1, giving full throughput of one result per cycle.
- Backpressure: while out_valid=1 and out_ready=0:
  - in_ready=0.
  - sum/carry/out_valid hold.
  - a/b are ignored.
- in_valid=0: outputs hold; no accept.
- Invariant: for any result, sum & carry == 0. With WIDTH=1, {carry,sum} = a + b as a 2-bit value.
- carry_cnt:
  - On each accept, carry_cnt <= carry_cnt + popcount(a & b), saturating at 2^CNT_W-1 (never wraps).
  - cnt_clr=1 has priority: carry_cnt <= 0 at that edge, and any increment in the same cycle is discarded.
- Reset mid-operation: a pending result is dropped (out_valid=0) and the count is lost. The first accept after release of rst_n behaves as from power-up.
- X-safety: a/b values while not accepted must not affect any state.

Decomposition:
- Package half_adder_pkg holds:
  - default width constants (HA_WIDTH_DEF=1, HA_CNT_W_DEF=16);
  - a packed struct ha_result_t {sum, carry} for the 1-bit lane;
  - a popcount function used for carry_cnt.
- One natural combinational sub-module, half_adder_cell: 1-bit a, b -> sum, carry. Instantiate it WIDTH times via generate. Registers, handshake and counter stay in half_adder_unit.

Test Plan:
- Truth table, WIDTH=1, out_ready=1, in_valid=1. Apply (a,b) = (0,0), (1,0), (0,1), (1,1), (0,0) on successive cycles. Each result appears one cycle later as (sum,carry) = (0,0), (1,0), (1,0), (0,1), (0,0). carry_cnt ends at 1.
- Reset: drive rst_n=0 asynchronously mid-cycle while out_valid=1. sum, carry, out_valid and carry_cnt go to 0 immediately, without a clock edge.
- Backpressure: out_ready=0 after accepting (1,1). in_ready=0, and carry=1, sum=0 hold for 5 cycles despite a/b changing. Raise out_ready with in_valid=1, a=1, b=0: the next result is sum=1, carry=0 with no bubble.
- Vector lanes, WIDTH=8: a=8'hF0, b=8'hCC. Result sum=8'h3C, carry=8'hC0, carry_cnt increments by 2.
- Counter, CNT_W=4, WIDTH=8:
  - Accept a=b=8'hFF twice. carry_cnt = 15 (saturated, not 0).
  - Assert cnt_clr together with an accept. carry_cnt = 0.

Source files
------------

// File: rtl/half_adder_pkg.sv
// Shared constants, the 1-bit lane result type and the popcount helper
// for the registered half-adder array.
package half_adder_pkg;

    localparam int HA_WIDTH_DEF = 1;
    localparam int HA_CNT_W_DEF = 16;

    // Result of one independent half-adder lane.
    typedef struct packed {
        logic sum;
        logic carry;
    } ha_result_t;

    // Number of set bits in a 64-bit vector; narrower lanes are zero-extended by the caller.
    function automatic int unsigned popcount64(input logic [63:0] v);
        int unsigned cnt;
        cnt = 0;
        for (int i = 0; i < 64; i++) begin
            cnt += {31'b0, v[i]};
        end
        return cnt;
    endfunction

endpackage

// File: rtl/half_adder_cell.sv
// Purely combinational 1-bit half adder: sum = a ^ b, carry = a & b.
module half_adder_cell
    import half_adder_pkg::*;
(
    input  logic a_i,
    input  logic b_i,
    output logic sum_o,
    output logic carry_o
);

    ha_result_t res;

    assign res     = '{sum: a_i ^ b_i, carry: a_i & b_i};
    assign sum_o   = res.sum;
    assign carry_o = res.carry;

endmodule

// File: rtl/half_adder_unit.sv
// Registered array of independent half-adder lanes with a valid/ready
// output stage and a saturating count of carry bits in accepted results.
module half_adder_unit
    import half_adder_pkg::*;
#(
    parameter int WIDTH = HA_WIDTH_DEF,
    parameter int CNT_W = HA_CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] sum,
    output logic [WIDTH-1:0] carry,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CNT_W-1:0] carry_cnt,
    input  logic             cnt_clr
);

    // Extra headroom so one accept (at most 64 carries) cannot overflow before saturation.
    localparam int CW = CNT_W + 8;
    localparam logic [CW-1:0] CNT_MAX = {8'b0, {CNT_W{1'b1}}};

    logic [WIDTH-1:0] sum_d,   sum_q;
    logic [WIDTH-1:0] carry_d, carry_q;
    logic             out_valid_d, out_valid_q;
    logic [CNT_W-1:0] cnt_d, cnt_q;
    logic             accept;
    logic [CW-1:0]    cnt_wide;
    int unsigned      carry_pop;

    // One combinational half adder per lane; lanes never interact.
    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_lane
            half_adder_cell u_cell (
                .a_i     (a[gi]),
                .b_i     (b[gi]),
                .sum_o   (sum_d[gi]),
                .carry_o (carry_d[gi])
            );
        end
    endgenerate

    // Output register is free when empty or being drained this cycle.
    assign in_ready  = !out_valid_q || out_ready;
    assign accept    = in_valid && in_ready;
    assign carry_pop = popcount64(64'(carry_d));
    assign cnt_wide  = {8'b0, cnt_q} + CW'(carry_pop);

    // Next-state for the valid flag and the saturating carry counter.
    always_comb begin
        out_valid_d = out_valid_q;
        cnt_d       = cnt_q;
        if (accept) begin
            out_valid_d = 1'b1;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
        if (cnt_clr) begin
            cnt_d = '0;
        end else if (accept) begin
            cnt_d = (cnt_wide > CNT_MAX) ? {CNT_W{1'b1}} : cnt_wide[CNT_W-1:0];
        end
    end

    // Result/state registers; operands are only sampled on an accept so idle a/b never leak in.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q       <= '0;
            carry_q     <= '0;
            out_valid_q <= 1'b0;
            cnt_q       <= '0;
        end else begin
            if (accept) begin
                sum_q   <= sum_d;
                carry_q <= carry_d;
            end
            out_valid_q <= out_valid_d;
            cnt_q       <= cnt_d;
        end
    end

    assign sum       = sum_q;
    assign carry     = carry_q;
    assign out_valid = out_valid_q;
    assign carry_cnt = cnt_q;

endmodule

// File: tb/tb_half_adder_unit.sv
// Bench for half_adder_unit: a 1-bit default instance and an 8-lane instance
// with a 4-bit counter run side by side against an arithmetic reference model.
module tb_half_adder_unit;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0, out_ready = 1'b0, cnt_clr = 1'b0;
    logic [0:0] a1 = '0, b1 = '0;
    logic [7:0] a8 = '0, b8 = '0;

    logic       in_ready1, out_valid1, in_ready8, out_valid8;
    logic [0:0] sum1, carry1;
    logic [7:0] sum8, carry8;
    logic [15:0] cnt1;
    logic [3:0]  cnt8;

    int n_cmp = 0;
    int n_fail = 0;

    // Reference model state
    logic       ev1, ev8;
    logic [0:0] es1, ec1;
    logic [7:0] es8, ec8;
    int         ecnt1, ecnt8;

    always #5 clk = ~clk;

    half_adder_unit u_w1 (
        .clk(clk), .rst_n(rst_n), .a(a1), .b(b1), .in_valid(in_valid),
        .in_ready(in_ready1), .sum(sum1), .carry(carry1), .out_valid(out_valid1),
        .out_ready(out_ready), .carry_cnt(cnt1), .cnt_clr(cnt_clr)
    );

    half_adder_unit #(.WIDTH(8), .CNT_W(4)) u_w8 (
        .clk(clk), .rst_n(rst_n), .a(a8), .b(b8), .in_valid(in_valid),
        .in_ready(in_ready8), .sum(sum8), .carry(carry8), .out_valid(out_valid8),
        .out_ready(out_ready), .carry_cnt(cnt8), .cnt_clr(cnt_clr)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        ev1 = 0; es1 = '0; ec1 = '0; ecnt1 = 0;
        ev8 = 0; es8 = '0; ec8 = '0; ecnt8 = 0;
    endtask

    task automatic check_outputs(input string when);
        chk({when, " w1_sum"},   64'(sum1),   64'(es1));
        chk({when, " w1_carry"}, 64'(carry1), 64'(ec1));
        chk({when, " w1_valid"}, 64'(out_valid1), 64'(ev1));
        chk({when, " w1_cnt"},   64'(cnt1),   64'(ecnt1));
        chk({when, " w8_sum"},   64'(sum8),   64'(es8));
        chk({when, " w8_carry"}, 64'(carry8), 64'(ec8));
        chk({when, " w8_valid"}, 64'(out_valid8), 64'(ev8));
        chk({when, " w8_cnt"},   64'(cnt8),   64'(ecnt8));
    endtask

    // One clock of stimulus; the 1-bit instance sees bit 0 of the operands.
    task automatic step(input logic [7:0] av, input logic [7:0] bv,
                        input logic iv, input logic ordy, input logic clr);
        logic acc1, acc8;
        int   s, pop;
        a8 = av; b8 = bv; a1 = av[0:0]; b1 = bv[0:0];
        in_valid = iv; out_ready = ordy; cnt_clr = clr;
        #1;
        chk("w1_in_ready", 64'(in_ready1), 64'(!ev1 || ordy));
        chk("w8_in_ready", 64'(in_ready8), 64'(!ev8 || ordy));
        acc1 = iv && (!ev1 || ordy);
        acc8 = iv && (!ev8 || ordy);
        @(posedge clk);
        // 1-bit lane: {carry,sum} is the 2-bit arithmetic sum of a and b
        if (acc1) begin
            s = int'(av[0]) + int'(bv[0]);
            {ec1, es1} = 2'(s);
            ev1 = 1;
        end else if (ordy) begin
            ev1 = 0;
        end
        if (clr) ecnt1 = 0;
        else if (acc1) ecnt1 = (ecnt1 + int'(ec1) > 65535) ? 65535 : ecnt1 + int'(ec1);
        // 8 lanes, each an independent arithmetic sum
        if (acc8) begin
            pop = 0;
            for (int i = 0; i < 8; i++) begin
                s = int'(av[i]) + int'(bv[i]);
                es8[i] = (s % 2) == 1;
                ec8[i] = (s / 2) == 1;
                pop += s / 2;
            end
            ev8 = 1;
        end else if (ordy) begin
            ev8 = 0;
        end
        if (clr) ecnt8 = 0;
        else if (acc8) begin
            pop = 0;
            for (int i = 0; i < 8; i++) pop += (int'(av[i]) + int'(bv[i])) / 2;
            ecnt8 = (ecnt8 + pop > 15) ? 15 : ecnt8 + pop;
        end
        #1;
        check_outputs("step");
        $display("t=%0t a=%02h b=%02h iv=%0b ordy=%0b clr=%0b | w1 s=%0b c=%0b v=%0b n=%0d | w8 s=%02h c=%02h v=%0b n=%0d",
                 $time, av, bv, iv, ordy, clr, sum1, carry1, out_valid1, cnt1,
                 sum8, carry8, out_valid8, cnt8);
    endtask

    initial begin
        logic [7:0] ra, rb;
        model_reset();

        // Power-up reset
        #12;
        check_outputs("reset");
        rst_n = 1'b1;
        #2;

        // Truth table on the 1-bit lane, full throughput
        step(8'h00, 8'h00, 1, 1, 0);
        step(8'h01, 8'h00, 1, 1, 0);
        step(8'h00, 8'h01, 1, 1, 0);
        step(8'h01, 8'h01, 1, 1, 0);
        step(8'h00, 8'h00, 1, 1, 0);
        chk("truth_table_cnt", 64'(cnt1), 64'd1);

        // Asynchronous reset mid-cycle with a pending result
        step(8'hFF, 8'h81, 1, 0, 0);
        rst_n = 1'b0;
        #2;
        model_reset();
        check_outputs("async_reset");
        #10;
        rst_n = 1'b1;

        // Backpressure: hold (1,1) result while operands change
        step(8'h01, 8'h01, 1, 1, 0);
        for (int i = 0; i < 5; i++) begin
            ra = 8'($urandom); rb = 8'($urandom);
            step(ra, rb, 1, 0, 0);
        end
        chk("bp_hold_carry", 64'(carry1), 64'd1);
        step(8'h01, 8'h00, 1, 1, 0);
        chk("bp_release_sum", 64'(sum1), 64'd1);

        // Vector lanes after clearing the counter
        step(8'h00, 8'h00, 0, 1, 1);
        step(8'hF0, 8'hCC, 1, 1, 0);
        chk("vec_sum", 64'(sum8), 64'h3C);
        chk("vec_cnt", 64'(cnt8), 64'd2);

        // Counter saturation on the 4-bit counter, then clear beating an accept
        step(8'hFF, 8'hFF, 1, 1, 0);
        step(8'hFF, 8'hFF, 1, 1, 0);
        chk("sat_cnt", 64'(cnt8), 64'd15);
        step(8'hFF, 8'hFF, 1, 1, 1);
        chk("clr_cnt", 64'(cnt8), 64'd0);

        // Idle operands must not disturb anything
        for (int i = 0; i < 4; i++) begin
            ra = 8'($urandom); rb = 8'($urandom);
            step(ra, rb, 0, 0, 0);
        end

        // Random traffic
        for (int i = 0; i < 200; i++) begin
            ra = 8'($urandom); rb = 8'($urandom);
            step(ra, rb, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) != 0),
                 1'($urandom_range(0, 15) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
